noc_output_arbiter: RTL

- Per-output-port switch allocator for the mesh router. One instance per output direction (LOCAL/NORTH/SOUTH/EAST/WEST).
- Arbitrates the input ports requesting that output: QoS priority first, round-robin among equal QoS.
- Locks the output to the winner from head flit to tail flit, and gates every flit transfer on credit-based downstream flow control.

---
 rtl/noc_output_arbiter_if.sv | 30 +++
 rtl/noc_output_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter_if.sv
// Request/grant and credit bundle between input ports and one output arbiter.
// master: requester side; slave: the arbiter.
interface noc_output_arbiter_if #(
   parameter int NUM_IN       = 5,
   parameter int QOS_W        = 2,
   parameter int CREDIT_DEPTH = 4
);
   localparam int CW = $clog2(CREDIT_DEPTH + 1);

   logic [NUM_IN-1:0]       req_valid;
   logic [NUM_IN-1:0]       req_head;
   logic [NUM_IN-1:0]       req_tail;
   logic [NUM_IN*QOS_W-1:0] req_qos;
   logic                    credit_return;
   logic [NUM_IN-1:0]       grant;
   logic                    xfer;
   logic [CW-1:0]           credit_count;
   logic [31:0]             packets_granted;
   logic                    credit_overflow;

   modport master (
      output req_valid, req_head, req_tail, req_qos, credit_return,
      input  grant, xfer, credit_count, packets_granted, credit_overflow
   );

   modport slave (
      input  req_valid, req_head, req_tail, req_qos, credit_return,
      output grant, xfer, credit_count, packets_granted, credit_overflow
   );
endinterface

// File: rtl/noc_output_arbiter.sv
// Per-output switch allocator: QoS + round-robin, packet lock, credit flow control.
// Optional starvation aging enabled by defining NOC_OUTPUT_ARB_AGING_EN.
module noc_output_arbiter #(
   parameter int NUM_IN       = 5,
   parameter int QOS_W        = 2,
   parameter int CREDIT_DEPTH = 4,
   parameter int STARVE_LIMIT = 16
) (
   input logic clk,
   input logic rst_n,
   noc_output_arbiter_if.slave bus
);
   localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int CW     = $clog2(CREDIT_DEPTH + 1);
   localparam int PRIO_W = QOS_W + 1;
   localparam logic [CW-1:0]    CRED_MAX = CW'(CREDIT_DEPTH);
   localparam logic [PTR_W-1:0] LAST_IN  = PTR_W'(NUM_IN - 1);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e            state_q, state_d;
   logic [NUM_IN-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [CW-1:0]     credit_q, credit_d;
   logic [31:0]       pkt_q, pkt_d;
   logic              ovf_q, ovf_d;

   logic [NUM_IN-1:0] cand;
   logic [PRIO_W-1:0] prio [NUM_IN];
   logic [PRIO_W-1:0] max_prio;
   logic              win_vld;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  idx;
   logic              xfer;
   logic              tail_xfer;

   assign cand = bus.req_valid & bus.req_head;

`ifdef NOC_OUTPUT_ARB_AGING_EN
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT);

   logic [AGE_W-1:0] age_q [NUM_IN];
   logic [AGE_W-1:0] age_d [NUM_IN];

   // A starved requester outranks every QoS level via the extra top bit.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         prio[i] = {age_q[i] >= AGE_LIM, bus.req_qos[i*QOS_W +: QOS_W]};
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         age_d[i] = age_q[i];
         if (state_q == IDLE && win_vld) begin
            if (PTR_W'(i) == win_idx) begin
               age_d[i] = '0;
            end else if (cand[i] && age_q[i] < AGE_LIM) begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IN; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         prio[i] = {1'b0, bus.req_qos[i*QOS_W +: QOS_W]};
      end
   end
`endif

   always_comb begin
      max_prio = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (cand[i] && prio[i] > max_prio) begin
            max_prio = prio[i];
         end
      end
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      // Walk candidates starting at rr_ptr so equal-priority ties rotate.
      for (int k = 0; k < NUM_IN; k++) begin
         idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_IN);
         if (!win_vld && cand[idx] && prio[idx] == max_prio) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   assign xfer = (state_q == LOCKED)
              && |(grant_q & bus.req_valid)
              && (credit_q != '0);
   assign tail_xfer = xfer && |(grant_q & bus.req_tail);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      pkt_d    = pkt_q;
      ovf_d    = ovf_q;
      credit_d = credit_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = LOCKED;
               grant_d = NUM_IN'(1) << win_idx;
               owner_d = win_idx;
            end
         end
         LOCKED: begin
            if (tail_xfer) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = (owner_q == LAST_IN) ? '0 : owner_q + 1'b1;
               pkt_d    = pkt_q + 32'd1;
            end
         end
      endcase
      if (xfer && !bus.credit_return) begin
         credit_d = credit_q - 1'b1;
      end else if (!xfer && bus.credit_return) begin
         if (credit_q == CRED_MAX) begin
            ovf_d = 1'b1;
         end else begin
            credit_d = credit_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         credit_q <= CRED_MAX;
         pkt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         pkt_q    <= pkt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.grant           = grant_q;
   assign bus.xfer            = xfer;
   assign bus.credit_count    = credit_q;
   assign bus.packets_granted = pkt_q;
   assign bus.credit_overflow = ovf_q;
endmodule
